// File: rtl/vga_logo_scanner_pkg.sv
// Shared 800x600@72Hz timing constants, widths and payload types for the logo scanner.
package vga_logo_scanner_pkg;

  localparam int unsigned CNT_W = 11;
  localparam int unsigned CH_W  = 3;
  localparam int unsigned RGB_W = 3 * CH_W;

  localparam int unsigned H_ACT_DEF = 800;
  localparam int unsigned H_FP_DEF  = 56;
  localparam int unsigned H_SW_DEF  = 120;
  localparam int unsigned H_BP_DEF  = 64;
  localparam int unsigned V_ACT_DEF = 600;
  localparam int unsigned V_FP_DEF  = 37;
  localparam int unsigned V_SW_DEF  = 6;
  localparam int unsigned V_BP_DEF  = 23;

  localparam int unsigned H_TOTAL = H_ACT_DEF + H_FP_DEF + H_SW_DEF + H_BP_DEF;
  localparam int unsigned V_TOTAL = V_ACT_DEF + V_FP_DEF + V_SW_DEF + V_BP_DEF;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

  typedef struct packed {
    logic [CH_W-1:0] r;
    logic [CH_W-1:0] g;
    logic [CH_W-1:0] b;
  } rgb_t;

endpackage

// File: rtl/vga_logo_scanner_timing.sv
// Raster counters plus stage-0 decode: sync windows, active area and last-pixel flag.
module vga_logo_scanner_timing
  import vga_logo_scanner_pkg::*;
#(
  parameter int unsigned H_ACT    = H_ACT_DEF,
  parameter int unsigned H_FP     = H_FP_DEF,
  parameter int unsigned H_SW     = H_SW_DEF,
  parameter int unsigned H_BP     = H_BP_DEF,
  parameter int unsigned V_ACT    = V_ACT_DEF,
  parameter int unsigned V_FP     = V_FP_DEF,
  parameter int unsigned V_SW     = V_SW_DEF,
  parameter int unsigned V_BP     = V_BP_DEF,
  parameter bit          SYNC_POL = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  output logic [CNT_W-1:0] x,
  output logic [CNT_W-1:0] y,
  output logic             hs0_c,
  output logic             vs0_c,
  output logic             active_c,
  output logic             frame_end_c
);

  localparam int unsigned H_TOT = H_ACT + H_FP + H_SW + H_BP;
  localparam int unsigned V_TOT = V_ACT + V_FP + V_SW + V_BP;

  localparam logic [CNT_W-1:0] X_LAST = CNT_W'(H_TOT - 1);
  localparam logic [CNT_W-1:0] Y_LAST = CNT_W'(V_TOT - 1);
  localparam logic [CNT_W-1:0] X_ACT  = CNT_W'(H_ACT);
  localparam logic [CNT_W-1:0] Y_ACT  = CNT_W'(V_ACT);
  localparam logic [CNT_W-1:0] HS_ON  = CNT_W'(H_ACT + H_FP);
  localparam logic [CNT_W-1:0] HS_OFF = CNT_W'(H_ACT + H_FP + H_SW);
  localparam logic [CNT_W-1:0] VS_ON  = CNT_W'(V_ACT + V_FP);
  localparam logic [CNT_W-1:0] VS_OFF = CNT_W'(V_ACT + V_FP + V_SW);

  logic line_end_c;

  assign line_end_c  = (x == X_LAST);
  assign frame_end_c = line_end_c && (y == Y_LAST);
  assign active_c    = (x < X_ACT) && (y < Y_ACT);
  assign hs0_c       = ((x >= HS_ON) && (x < HS_OFF)) ? SYNC_POL : ~SYNC_POL;
  assign vs0_c       = ((y >= VS_ON) && (y < VS_OFF)) ? SYNC_POL : ~SYNC_POL;

  // Pixel counter wraps each line; line counter advances on line end and wraps per frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x <= '0;
      y <= '0;
    end else if (line_end_c) begin
      x <= '0;
      y <= (y == Y_LAST) ? '0 : y + CNT_W'(1);
    end else begin
      x <= x + CNT_W'(1);
    end
  end

endmodule

// File: rtl/vga_logo_scanner.sv
// Raster source for the logo painters: scroll bouncer, frame divider and aligned colour/sync stage.
module vga_logo_scanner
  import vga_logo_scanner_pkg::*;
#(
  parameter int unsigned      H_ACT     = H_ACT_DEF,
  parameter int unsigned      H_FP      = H_FP_DEF,
  parameter int unsigned      H_SW      = H_SW_DEF,
  parameter int unsigned      H_BP      = H_BP_DEF,
  parameter int unsigned      V_ACT     = V_ACT_DEF,
  parameter int unsigned      V_FP      = V_FP_DEF,
  parameter int unsigned      V_SW      = V_SW_DEF,
  parameter int unsigned      V_BP      = V_BP_DEF,
  parameter bit               SYNC_POL  = 1'b1,
  parameter int unsigned      DELT_MAX  = 200,
  parameter int unsigned      FRAME_DIV = 2,
  parameter logic [RGB_W-1:0] FG_RGB    = 9'h1FF,
  parameter logic [RGB_W-1:0] BG_RGB    = 9'h000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             scroll_en,
  input  logic             hit,
  output logic [CNT_W-1:0] x,
  output logic [CNT_W-1:0] y,
  output logic [CNT_W-1:0] delt,
  output logic             frame_sof,
  output logic             hs,
  output logic             vs,
  output logic [CH_W-1:0]  r,
  output logic [CH_W-1:0]  g,
  output logic [CH_W-1:0]  b
);

  localparam int unsigned      FDW     = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam logic [FDW-1:0]   FD_LAST = FDW'(FRAME_DIV - 1);
  localparam logic [CNT_W-1:0] DMAX    = CNT_W'(DELT_MAX);
  localparam logic [CNT_W-1:0] DMAX_M1 = CNT_W'(DELT_MAX - 1);

  logic             hs0_c;
  logic             vs0_c;
  logic             active_c;
  logic             frame_end_c;
  logic             step_c;
  dir_t             dir;
  dir_t             dir_next;
  logic [CNT_W-1:0] delt_next;
  logic [FDW-1:0]   fcnt;
  logic [FDW-1:0]   fcnt_next;
  rgb_t             pix;

  vga_logo_scanner_timing #(
    .H_ACT    (H_ACT),
    .H_FP     (H_FP),
    .H_SW     (H_SW),
    .H_BP     (H_BP),
    .V_ACT    (V_ACT),
    .V_FP     (V_FP),
    .V_SW     (V_SW),
    .V_BP     (V_BP),
    .SYNC_POL (SYNC_POL)
  ) u_timing (
    .clk         (clk),
    .rst         (rst),
    .x           (x),
    .y           (y),
    .hs0_c       (hs0_c),
    .vs0_c       (vs0_c),
    .active_c    (active_c),
    .frame_end_c (frame_end_c)
  );

  // Bouncer state: direction, scroll offset and frame divider, all updated only at frame end.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dir  <= DIR_UP;
      delt <= '0;
      fcnt <= '0;
    end else begin
      dir  <= dir_next;
      delt <= delt_next;
      fcnt <= fcnt_next;
    end
  end

  // Frame divider and direction reversal at the travel limits.
  always_comb begin
    fcnt_next = fcnt;
    step_c    = 1'b0;
    dir_next  = dir;
    if (frame_end_c) begin
      if (fcnt == FD_LAST) begin
        fcnt_next = '0;
        step_c    = scroll_en;
      end else begin
        fcnt_next = fcnt + FDW'(1);
      end
    end
    if (step_c) begin
      if ((dir == DIR_UP) && (delt == DMAX)) begin
        dir_next = DIR_DOWN;
      end else if ((dir == DIR_DOWN) && (delt == '0)) begin
        dir_next = DIR_UP;
      end
    end
  end

  // Next scroll offset; a limit hit reflects immediately so delt never overshoots.
  always_comb begin
    delt_next = delt;
    if (step_c) begin
      if (dir == DIR_UP) begin
        delt_next = (delt == DMAX) ? DMAX_M1 : delt + CNT_W'(1);
      end else begin
        delt_next = (delt == '0) ? CNT_W'(1) : delt - CNT_W'(1);
      end
    end
  end

  // Stage 1: register syncs, start-of-frame and colour together so they leave aligned.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hs        <= ~SYNC_POL;
      vs        <= ~SYNC_POL;
      frame_sof <= 1'b0;
      pix       <= '0;
    end else begin
      hs        <= hs0_c;
      vs        <= vs0_c;
      frame_sof <= frame_end_c;
      pix       <= active_c ? rgb_t'(hit ? FG_RGB : BG_RGB) : '0;
    end
  end

  assign r = pix.r;
  assign g = pix.g;
  assign b = pix.b;

endmodule

// File: tb/tb_vga_logo_scanner.sv
// Scoreboard bench for vga_logo_scanner on a shrunken raster (30x18) so whole frames stay short.
module tb_vga_logo_scanner;

  localparam int H_ACT = 16;
  localparam int H_FP  = 4;
  localparam int H_SW  = 6;
  localparam int H_BP  = 4;
  localparam int V_ACT = 10;
  localparam int V_FP  = 3;
  localparam int V_SW  = 2;
  localparam int V_BP  = 3;
  localparam int H_TOT = H_ACT + H_FP + H_SW + H_BP;
  localparam int V_TOT = V_ACT + V_FP + V_SW + V_BP;
  localparam int FRAME = H_TOT * V_TOT;
  localparam int DMAX  = 3;
  localparam logic [8:0] FG = 9'h1FF;
  localparam logic [8:0] BG = 9'h049;

  logic        clk;
  logic        rst;
  logic        scroll_en;
  logic        hit;
  logic [10:0] ax, ay, adelt, bx, by, bdelt;
  logic        asof, ahs, avs, bsof, bhs, bvs;
  logic [2:0]  ar, ag, ab, br, bg, bb;

  typedef struct {
    logic       hs;
    logic       vs;
    logic [8:0] rgb;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;
  int   mx, my, mda, mdb, mfa, mfb;
  bit   mua, mub;
  logic msof;

  vga_logo_scanner #(
    .H_ACT(H_ACT), .H_FP(H_FP), .H_SW(H_SW), .H_BP(H_BP),
    .V_ACT(V_ACT), .V_FP(V_FP), .V_SW(V_SW), .V_BP(V_BP),
    .SYNC_POL(1'b1), .DELT_MAX(DMAX), .FRAME_DIV(1), .FG_RGB(FG), .BG_RGB(BG)
  ) ua (
    .clk(clk), .rst(rst), .scroll_en(scroll_en), .hit(hit),
    .x(ax), .y(ay), .delt(adelt), .frame_sof(asof),
    .hs(ahs), .vs(avs), .r(ar), .g(ag), .b(ab)
  );

  vga_logo_scanner #(
    .H_ACT(H_ACT), .H_FP(H_FP), .H_SW(H_SW), .H_BP(H_BP),
    .V_ACT(V_ACT), .V_FP(V_FP), .V_SW(V_SW), .V_BP(V_BP),
    .SYNC_POL(1'b1), .DELT_MAX(DMAX), .FRAME_DIV(2), .FG_RGB(FG), .BG_RGB(BG)
  ) ub (
    .clk(clk), .rst(rst), .scroll_en(scroll_en), .hit(hit),
    .x(bx), .y(by), .delt(bdelt), .frame_sof(bsof),
    .hs(bhs), .vs(bvs), .r(br), .g(bg), .b(bb)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  task automatic model_reset();
    mx = 0; my = 0; mda = 0; mdb = 0; mfa = 0; mfb = 0;
    mua = 1'b1; mub = 1'b1; msof = 1'b0;
    q.delete();
  endtask

  task automatic bounce(inout int d, inout bit up, inout int fc, input int div, input logic en);
    fc = fc + 1;
    if (fc == div) begin
      fc = 0;
      if (en) begin
        if (up) begin
          if (d == DMAX) begin up = 1'b0; d = DMAX - 1; end
          else d = d + 1;
        end else begin
          if (d == 0) begin up = 1'b1; d = 1; end
          else d = d - 1;
        end
      end
    end
  endtask

  // Drives one pixel's inputs, queues its stage-1 expectation, advances the model, waits to negedge.
  task automatic step(input logic h, input logic en);
    exp_t e;
    bit   fe;
    e.hs  = (mx >= H_ACT + H_FP) && (mx < H_ACT + H_FP + H_SW);
    e.vs  = (my >= V_ACT + V_FP) && (my < V_ACT + V_FP + V_SW);
    e.rgb = ((mx < H_ACT) && (my < V_ACT)) ? (h ? FG : BG) : 9'h000;
    q.push_back(e);
    hit       = h;
    scroll_en = en;
    fe   = (mx == H_TOT - 1) && (my == V_TOT - 1);
    msof = fe;
    if (fe) begin
      bounce(mda, mua, mfa, 1, en);
      bounce(mdb, mub, mfb, 2, en);
    end
    if (mx == H_TOT - 1) begin
      mx = 0;
      my = (my == V_TOT - 1) ? 0 : my + 1;
    end else begin
      mx = mx + 1;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    exp_t e;
    rst = 1'b0; hit = 1'b0; scroll_en = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (ax !== 11'd0 || ay !== 11'd0 || adelt !== 11'd0 || asof !== 1'b0 ||
        ahs !== 1'b0 || avs !== 1'b0 || {ar, ag, ab} !== 9'h000) begin
      failures++;
      $display("FAIL reset_state: x=%0d y=%0d delt=%0d sof=%b hs=%b vs=%b rgb=%h want all zero",
               ax, ay, adelt, asof, ahs, avs, {ar, ag, ab});
    end
    rst = 1'b1;
    model_reset();
    repeat (8) step(1'b0, 1'b1);
    e = q[$];
    checks++;
    if (ax !== 11'(mx) || {ar, ag, ab} !== e.rgb) begin
      failures++;
      $display("FAIL reset_preline: x=%0d rgb=%h want x=%0d rgb=%h", ax, {ar, ag, ab}, mx, e.rgb);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (ax !== 11'd0 || ay !== 11'd0 || ahs !== 1'b0 || avs !== 1'b0 ||
        {ar, ag, ab} !== 9'h000 || adelt !== 11'd0 || asof !== 1'b0) begin
      failures++;
      $display("FAIL reset_async: x=%0d y=%0d hs=%b rgb=%h delt=%0d want idle zeros",
               ax, ay, ahs, {ar, ag, ab}, adelt);
    end
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    step(1'b0, 1'b1);
    e = q.pop_front();
    checks++;
    if (ax !== 11'd1 || ay !== 11'd0 || {ar, ag, ab} !== e.rgb || ahs !== e.hs) begin
      failures++;
      $display("FAIL reset_resume: x=%0d y=%0d rgb=%h want x=1 y=0 rgb=%h", ax, ay, {ar, ag, ab}, e.rgb);
    end
  endtask

  task automatic test_timing();
    exp_t e;
    int   nhs = 0, nvs = 0, nsof = 0, nx0 = 0;
    logic phs, pvs;
    q.delete();
    phs = ahs;
    pvs = avs;
    for (int i = 0; i < FRAME; i++) begin
      step(1'b0, 1'b1);
      e = q.pop_front();
      checks++;
      if (ax !== 11'(mx) || ay !== 11'(my)) begin
        failures++;
        $display("FAIL timing_xy: x=%0d y=%0d want x=%0d y=%0d", ax, ay, mx, my);
      end
      checks++;
      if (ahs !== e.hs || avs !== e.vs) begin
        failures++;
        $display("FAIL timing_sync: hs=%b vs=%b want hs=%b vs=%b at x=%0d y=%0d", ahs, avs, e.hs, e.vs, mx, my);
      end
      checks++;
      if ({ar, ag, ab} !== e.rgb) begin
        failures++;
        $display("FAIL timing_rgb: rgb=%h want %h at x=%0d y=%0d", {ar, ag, ab}, e.rgb, mx, my);
      end
      checks++;
      if (asof !== msof) begin
        failures++;
        $display("FAIL timing_sof: sof=%b want %b at x=%0d y=%0d", asof, msof, mx, my);
      end
      if (ahs === 1'b1 && phs === 1'b0) begin
        checks++;
        if (mx != H_ACT + H_FP + 1) begin
          failures++;
          $display("FAIL hs_start: hs rose with x=%0d want x=%0d", mx, H_ACT + H_FP + 1);
        end
      end
      if (avs === 1'b1 && pvs === 1'b0) begin
        checks++;
        if (mx != 1 || my != V_ACT + V_FP) begin
          failures++;
          $display("FAIL vs_start: vs rose at x=%0d y=%0d want x=1 y=%0d", mx, my, V_ACT + V_FP);
        end
      end
      phs = ahs;
      pvs = avs;
      if (ahs === 1'b1) nhs++;
      if (avs === 1'b1) nvs++;
      if (asof === 1'b1) nsof++;
      if (ax === 11'd0) nx0++;
    end
    checks++;
    if (nhs != H_SW * V_TOT || nvs != V_SW * H_TOT) begin
      failures++;
      $display("FAIL sync_width: hs cycles=%0d vs cycles=%0d want %0d %0d", nhs, nvs, H_SW * V_TOT, V_SW * H_TOT);
    end
    checks++;
    if (nsof != 1 || nx0 != V_TOT) begin
      failures++;
      $display("FAIL frame_period: sof=%0d line starts=%0d want 1 %0d", nsof, nx0, V_TOT);
    end
  endtask

  task automatic test_colour();
    exp_t e;
    int   nfg = 0;
    logic h;
    for (int k = 0; k < FRAME && !(mx == 0 && my == 0); k++) step(1'b0, 1'b1);
    q.delete();
    for (int i = 0; i < FRAME; i++) begin
      h = ((mx == 5) && (my == 7)) || (mx == H_ACT + 4);
      step(h, 1'b1);
      e = q.pop_front();
      checks++;
      if ({ar, ag, ab} !== e.rgb) begin
        failures++;
        $display("FAIL colour_rgb: rgb=%h want %h at x=%0d y=%0d", {ar, ag, ab}, e.rgb, mx, my);
      end
      if ({ar, ag, ab} === FG) begin
        nfg++;
        checks++;
        if (mx != 6 || my != 7) begin
          failures++;
          $display("FAIL colour_align: fg seen at x=%0d y=%0d want x=6 y=7", mx, my);
        end
      end
    end
    checks++;
    if (nfg != 1) begin
      failures++;
      $display("FAIL colour_count: fg cycles=%0d want 1", nfg);
    end
  endtask

  task automatic test_bounce();
    int tbl_a[8] = '{0, 1, 2, 3, 2, 1, 0, 1};
    int tbl_b[8] = '{0, 0, 1, 1, 2, 2, 3, 3};
    int fi = 0, la = -1, lb = -1, na = 0, nb = 0;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    for (int k = 1; k < 8 * FRAME; k++) begin
      step(1'b0, 1'b1);
      if (mx == 0 && my == 0) fi++;
      checks++;
      if (adelt !== 11'(tbl_a[fi])) begin
        failures++;
        $display("FAIL bounce_div1: delt=%0d want %0d frame %0d", adelt, tbl_a[fi], fi);
      end
      checks++;
      if (bdelt !== 11'(tbl_b[fi])) begin
        failures++;
        $display("FAIL bounce_div2: delt=%0d want %0d frame %0d", bdelt, tbl_b[fi], fi);
      end
      if (asof === 1'b1) begin
        na++;
        if (la >= 0) begin
          checks++;
          if (k - la != FRAME) begin
            failures++;
            $display("FAIL sof_period_a: %0d want %0d", k - la, FRAME);
          end
        end
        la = k;
      end
      if (bsof === 1'b1) begin
        nb++;
        if (lb >= 0) begin
          checks++;
          if (k - lb != FRAME) begin
            failures++;
            $display("FAIL sof_period_b: %0d want %0d", k - lb, FRAME);
          end
        end
        lb = k;
      end
    end
    checks++;
    if (na != 7 || nb != 7) begin
      failures++;
      $display("FAIL sof_count: a=%0d b=%0d want 7 7", na, nb);
    end
  endtask

  task automatic test_freeze();
    step(1'b0, 1'b1);
    checks++;
    if (adelt !== 11'd2 || mx != 0 || my != 0) begin
      failures++;
      $display("FAIL freeze_entry: delt=%0d want 2", adelt);
    end
    for (int f = 0; f < 5; f++) begin
      for (int i = 0; i < FRAME; i++) step(1'b0, 1'(my == 5));
      checks++;
      if (adelt !== 11'd2) begin
        failures++;
        $display("FAIL freeze_hold: delt=%0d want 2 after frozen frame %0d", adelt, f);
      end
      checks++;
      if (bdelt !== 11'(mdb)) begin
        failures++;
        $display("FAIL freeze_hold_b: delt=%0d want %0d", bdelt, mdb);
      end
    end
    for (int i = 0; i < FRAME; i++) step(1'b0, 1'b1);
    checks++;
    if (adelt !== 11'd3) begin
      failures++;
      $display("FAIL freeze_resume: delt=%0d want 3", adelt);
    end
    for (int i = 0; i < FRAME; i++) step(1'b0, 1'b1);
    checks++;
    if (adelt !== 11'd2 || bdelt !== 11'(mdb)) begin
      failures++;
      $display("FAIL freeze_reflect: delt=%0d b=%0d want 2 %0d", adelt, bdelt, mdb);
    end
  endtask

  initial begin
    test_reset();
    test_timing();
    test_colour();
    test_bounce();
    test_freeze();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
